// File: rtl/memory_stage_pkg.sv
// Shared encodings for the RV32I MEM stage: result/store/load selectors and FSM states.
package memory_stage_pkg;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [1:0] ST_W = 2'b00;
  localparam logic [1:0] ST_H = 2'b01;
  localparam logic [1:0] ST_B = 2'b10;

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

  typedef enum logic {S_IDLE, S_WAIT} mem_state_e;

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory request/ready bus between the MEM stage (master) and memory (slave).
interface memory_stage_if #(parameter int ADDR_WIDTH = 10);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic [3:0]            be;
  logic [31:0]           rdata;
  logic                  ready;

  modport master (output req, we, addr, wdata, be, input rdata, ready);
  modport slave  (input req, we, addr, wdata, be, output rdata, ready);
endinterface

// File: rtl/memory_stage_load_extend.sv
// Lane-selects the addressed byte/half of a read word and sign- or zero-extends it.
module load_extend
  import memory_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  loadtype,
  output logic [31:0] result
);
  logic [31:0] sh;
  assign sh = rdata >> {off, 3'b000};

  always_comb begin
    result = sh;
    case (loadtype)
      LD_B:    result = {{24{sh[7]}}, sh[7:0]};
      LD_H:    result = {{16{sh[15]}}, sh[15:0]};
      LD_BU:   result = {24'h0, sh[7:0]};
      LD_HU:   result = {16'h0, sh[15:0]};
      default: result = sh;
    endcase
  end
endmodule

// File: rtl/memory_stage.sv
// RV32I MEM stage: drives data memory, stalls until ready or timeout, loads MEM/WB.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int TIMEOUT    = 15
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_alu_result_m,
  input  logic [DATA_WIDTH-1:0] i_write_data_m,
  input  logic                  i_regwrite_m,
  input  logic                  i_memwrite_m,
  input  logic [1:0]            i_resultsrc_m,
  input  logic [4:0]            i_rd_addr_m,
  input  logic [ADDR_WIDTH-1:0] i_pc4_m,
  input  logic [1:0]            i_storetype_m,
  input  logic [2:0]            i_loadtype_m,
  memory_stage_if.master        dmem,
  output logic                  o_stall_m,
  output logic [DATA_WIDTH-1:0] o_forward_m,
  output logic                  o_misaligned_m,
  output logic                  o_dmem_err,
  output logic                  o_regwrite_w,
  output logic [1:0]            o_resultsrc_w,
  output logic [4:0]            o_rd_addr_w,
  output logic [DATA_WIDTH-1:0] o_alu_result_w,
  output logic [DATA_WIDTH-1:0] o_read_data_w,
  output logic [ADDR_WIDTH-1:0] o_pc4_w
);
  localparam int CW = $clog2(TIMEOUT + 1);

  mem_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          req, stall, timed_out;
  logic          mem_op, is_half, is_word, misaligned;
  logic [1:0]    off;
  logic [3:0]    be;
  logic [31:0]   wdata, ld_data;

  assign off     = i_alu_result_m[1:0];
  assign mem_op  = i_memwrite_m | (i_resultsrc_m == RES_MEM);
  assign is_half = i_memwrite_m ? (i_storetype_m == ST_H)
                                : (i_loadtype_m == LD_H || i_loadtype_m == LD_HU);
  assign is_word = i_memwrite_m ? (i_storetype_m == ST_W) : (i_loadtype_m == LD_W);
  assign misaligned = mem_op & ((is_half & off[0]) | (is_word & (off != 2'b00)));

  always_comb begin
    be    = 4'b0000;
    wdata = i_write_data_m[31:0];
    if (i_memwrite_m) begin
      case (i_storetype_m)
        ST_B:    begin be = 4'b0001 << off; wdata = {4{i_write_data_m[7:0]}};  end
        ST_H:    begin be = 4'b0011 << off; wdata = {2{i_write_data_m[15:0]}}; end
        default: be = 4'b1111;
      endcase
    end
  end

  // Request/stall are gated by reset so a mid-access reset drops them at once.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    req       = 1'b0;
    stall     = 1'b0;
    timed_out = 1'b0;
    if (i_rst_n) begin
      case (state_q)
        S_IDLE: if (mem_op && !misaligned) begin
          req = 1'b1;
          if (!dmem.ready) begin
            stall   = 1'b1;
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        end
        S_WAIT: begin
          req = 1'b1;
          if (dmem.ready) begin
            state_d = S_IDLE;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            timed_out = 1'b1;
            err_d     = 1'b1;
            state_d   = S_IDLE;
          end else begin
            stall = 1'b1;
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  load_extend u_load_extend (
    .rdata    (dmem.rdata),
    .off      (off),
    .loadtype (i_loadtype_m),
    .result   (ld_data)
  );

  // Stalled or misaligned cycles write a bubble; only regwrite matters for it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_regwrite_w   <= 1'b0;
      o_resultsrc_w  <= '0;
      o_rd_addr_w    <= '0;
      o_alu_result_w <= '0;
      o_read_data_w  <= '0;
      o_pc4_w        <= '0;
    end else begin
      o_regwrite_w   <= i_regwrite_m & ~misaligned & ~stall;
      o_resultsrc_w  <= i_resultsrc_m;
      o_rd_addr_w    <= i_rd_addr_m;
      o_alu_result_w <= i_alu_result_m;
      o_read_data_w  <= timed_out ? '0 : DATA_WIDTH'(ld_data);
      o_pc4_w        <= i_pc4_m;
    end
  end

  assign dmem.req       = req;
  assign dmem.we        = req & i_memwrite_m;
  assign dmem.addr      = {i_alu_result_m[ADDR_WIDTH-1:2], 2'b00};
  assign dmem.wdata     = wdata;
  assign dmem.be        = be;
  assign o_stall_m      = stall;
  assign o_forward_m    = i_alu_result_m;
  assign o_misaligned_m = misaligned;
  assign o_dmem_err     = err_q;
endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: stores, loads, misalignment, wait states, timeout, reset.
module tb_memory_stage;
  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [31:0] i_alu_result_m, i_write_data_m;
  logic        i_regwrite_m, i_memwrite_m;
  logic [1:0]  i_resultsrc_m, i_storetype_m;
  logic [4:0]  i_rd_addr_m;
  logic [9:0]  i_pc4_m;
  logic [2:0]  i_loadtype_m;
  logic        o_stall_m, o_misaligned_m, o_dmem_err, o_regwrite_w;
  logic [31:0] o_forward_m, o_alu_result_w, o_read_data_w;
  logic [1:0]  o_resultsrc_w;
  logic [4:0]  o_rd_addr_w;
  logic [9:0]  o_pc4_w;
  int          n_pass = 0, n_total = 0, n_fail = 0;
  int          ns, nb;

  memory_stage_if #(.ADDR_WIDTH(10)) dif ();

  memory_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .TIMEOUT(15)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_alu_result_m(i_alu_result_m), .i_write_data_m(i_write_data_m),
    .i_regwrite_m(i_regwrite_m), .i_memwrite_m(i_memwrite_m),
    .i_resultsrc_m(i_resultsrc_m), .i_rd_addr_m(i_rd_addr_m), .i_pc4_m(i_pc4_m),
    .i_storetype_m(i_storetype_m), .i_loadtype_m(i_loadtype_m),
    .dmem(dif),
    .o_stall_m(o_stall_m), .o_forward_m(o_forward_m), .o_misaligned_m(o_misaligned_m),
    .o_dmem_err(o_dmem_err), .o_regwrite_w(o_regwrite_w), .o_resultsrc_w(o_resultsrc_w),
    .o_rd_addr_w(o_rd_addr_w), .o_alu_result_w(o_alu_result_w),
    .o_read_data_w(o_read_data_w), .o_pc4_w(o_pc4_w)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic mw, input logic [1:0] rs, input logic rw, input logic [4:0] rd,
                        input logic [1:0] st, input logic [2:0] lt, input logic [31:0] a,
                        input logic [31:0] wd, input logic [9:0] pc4);
    i_memwrite_m = mw; i_resultsrc_m = rs; i_regwrite_m = rw; i_rd_addr_m = rd;
    i_storetype_m = st; i_loadtype_m = lt; i_alu_result_m = a; i_write_data_m = wd;
    i_pc4_m = pc4;
  endtask

  // Drives ready high on cycle index ready_after; counts stalled cycles and non-bubbles.
  task automatic run_wait(input int ready_after, output int nstall, output int nbub);
    bit done = 1'b0;
    nstall = 0; nbub = 0;
    for (int c = 0; c < 40; c++) begin
      dif.ready = (c == ready_after);
      #1;
      if (!o_stall_m) begin done = 1'b1; break; end
      nstall++;
      @(posedge i_clk); #1;
      if (o_regwrite_w !== 1'b0) nbub++;
      @(negedge i_clk);
    end
    check("wait_bounded", {31'd0, done}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n = 1'b0;
    dif.ready = 1'b0; dif.rdata = '0;
    set_op(0, 2'b00, 0, 0, 2'b00, 3'b000, 0, 0, 0);
    @(posedge i_clk); #1;
    check("rst_req", {31'd0, dif.req}, 0);
    check("rst_stall", {31'd0, o_stall_m}, 0);
    check("rst_err", {31'd0, o_dmem_err}, 0);
    check("rst_regwrite_w", {31'd0, o_regwrite_w}, 0);
    check("rst_read_data_w", o_read_data_w, 0);
    @(negedge i_clk); i_rst_n = 1'b1;

    // SW 0x008
    @(negedge i_clk);
    set_op(1, 2'b00, 0, 0, 2'b00, 3'b010, 32'h008, 32'hDEADBEEF, 10'h00C);
    dif.ready = 1'b1; #1;
    check("sw_req", {31'd0, dif.req}, 1);
    check("sw_we", {31'd0, dif.we}, 1);
    check("sw_be", {28'd0, dif.be}, 32'hF);
    check("sw_wdata", dif.wdata, 32'hDEADBEEF);
    check("sw_addr", {22'd0, dif.addr}, 32'h008);
    check("sw_stall", {31'd0, o_stall_m}, 0);
    check("sw_forward", o_forward_m, 32'h008);

    // SB 0x013
    @(negedge i_clk);
    set_op(1, 2'b00, 0, 0, 2'b10, 3'b010, 32'h013, 32'h000000A5, 10'h010); #1;
    check("sb_be", {28'd0, dif.be}, 32'h8);
    check("sb_wdata", dif.wdata, 32'hA5A5A5A5);
    check("sb_addr", {22'd0, dif.addr}, 32'h010);
    check("sb_stall", {31'd0, o_stall_m}, 0);

    // SH 0x002
    @(negedge i_clk);
    set_op(1, 2'b00, 0, 0, 2'b01, 3'b010, 32'h002, 32'h00001234, 10'h014); #1;
    check("sh_be", {28'd0, dif.be}, 32'hC);
    check("sh_wdata", dif.wdata, 32'h12341234);

    // LB / LBU at 0x001, LH / LHU at 0x002
    @(negedge i_clk);
    set_op(0, 2'b01, 1, 5'd5, 2'b00, 3'b000, 32'h001, 0, 10'h018);
    dif.rdata = 32'h00008000; #1;
    check("lb_be", {28'd0, dif.be}, 0);
    check("lb_we", {31'd0, dif.we}, 0);
    check("lb_req", {31'd0, dif.req}, 1);
    @(posedge i_clk); #1;
    check("lb_data", o_read_data_w, 32'hFFFFFF80);
    check("lb_regwrite", {31'd0, o_regwrite_w}, 1);
    check("lb_rd", {27'd0, o_rd_addr_w}, 5);
    check("lb_resultsrc", {30'd0, o_resultsrc_w}, 1);
    @(negedge i_clk); i_loadtype_m = 3'b100;
    @(posedge i_clk); #1;
    check("lbu_data", o_read_data_w, 32'h00000080);
    @(negedge i_clk);
    set_op(0, 2'b01, 1, 5'd6, 2'b00, 3'b001, 32'h002, 0, 10'h01C);
    dif.rdata = 32'h80000000;
    @(posedge i_clk); #1;
    check("lh_data", o_read_data_w, 32'hFFFF8000);
    @(negedge i_clk); i_loadtype_m = 3'b101;
    @(posedge i_clk); #1;
    check("lhu_data", o_read_data_w, 32'h00008000);

    // ALU op passes through; ready with no request is ignored
    @(negedge i_clk);
    set_op(0, 2'b00, 1, 5'd4, 2'b00, 3'b000, 32'h12345678, 0, 10'h044); #1;
    check("alu_req", {31'd0, dif.req}, 0);
    check("alu_stall", {31'd0, o_stall_m}, 0);
    @(posedge i_clk); #1;
    check("alu_result_w", o_alu_result_w, 32'h12345678);
    check("alu_pc4_w", {22'd0, o_pc4_w}, 32'h044);
    check("alu_regwrite", {31'd0, o_regwrite_w}, 1);

    // LW with 3 wait cycles
    @(negedge i_clk);
    set_op(0, 2'b01, 1, 5'd7, 2'b00, 3'b010, 32'h020, 0, 10'h048);
    dif.rdata = 32'hCAFEF00D;
    run_wait(3, ns, nb);
    check("lw_stall_cycles", ns, 3);
    check("lw_bubbles", nb, 0);
    check("lw_done_req", {31'd0, dif.req}, 1);
    @(posedge i_clk); #1;
    check("lw_commit", {31'd0, o_regwrite_w}, 1);
    check("lw_data", o_read_data_w, 32'hCAFEF00D);
    check("lw_rd", {27'd0, o_rd_addr_w}, 7);

    // Misaligned LH 0x001 and SW 0x002
    @(negedge i_clk);
    set_op(0, 2'b01, 1, 5'd8, 2'b00, 3'b001, 32'h001, 0, 10'h04C);
    dif.ready = 1'b1; #1;
    check("mis_lh_flag", {31'd0, o_misaligned_m}, 1);
    check("mis_lh_req", {31'd0, dif.req}, 0);
    check("mis_lh_stall", {31'd0, o_stall_m}, 0);
    @(posedge i_clk); #1;
    check("mis_lh_bubble", {31'd0, o_regwrite_w}, 0);
    @(negedge i_clk);
    set_op(1, 2'b00, 0, 0, 2'b00, 3'b010, 32'h002, 32'h1, 10'h050); #1;
    check("mis_sw_flag", {31'd0, o_misaligned_m}, 1);
    check("mis_sw_we", {31'd0, dif.we}, 0);

    // Timeout: ready never comes
    @(negedge i_clk);
    set_op(0, 2'b01, 1, 5'd9, 2'b00, 3'b010, 32'h030, 0, 10'h054);
    dif.rdata = 32'h11111111;
    run_wait(1000, ns, nb);
    check("to_stall_cycles", ns, 15);
    check("to_bubbles", nb, 0);
    check("to_err_before", {31'd0, o_dmem_err}, 0);
    @(posedge i_clk); #1;
    check("to_err", {31'd0, o_dmem_err}, 1);
    check("to_commit", {31'd0, o_regwrite_w}, 1);
    check("to_data_zero", o_read_data_w, 0);
    @(negedge i_clk);
    set_op(0, 2'b01, 1, 5'd10, 2'b00, 3'b010, 32'h034, 0, 10'h058);
    dif.ready = 1'b1; dif.rdata = 32'h00000042; #1;
    check("to_idle_req", {31'd0, dif.req}, 1);
    check("to_idle_stall", {31'd0, o_stall_m}, 0);
    @(posedge i_clk); #1;
    check("to_next_data", o_read_data_w, 32'h00000042);
    check("to_err_sticky", {31'd0, o_dmem_err}, 1);

    // Reset in the middle of WAIT
    @(negedge i_clk);
    set_op(0, 2'b01, 1, 5'd3, 2'b00, 3'b010, 32'h040, 0, 10'h05C);
    dif.ready = 1'b0; #1;
    check("rw_stall", {31'd0, o_stall_m}, 1);
    @(posedge i_clk); @(posedge i_clk); #2;
    i_rst_n = 1'b0; #1;
    check("rw_req", {31'd0, dif.req}, 0);
    check("rw_stall_clr", {31'd0, o_stall_m}, 0);
    check("rw_err_clr", {31'd0, o_dmem_err}, 0);
    check("rw_alu_w", o_alu_result_w, 0);
    check("rw_pc4_w", {22'd0, o_pc4_w}, 0);
    check("rw_rd_w", {27'd0, o_rd_addr_w}, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1; dif.ready = 1'b1; dif.rdata = 32'h0BADF00D; #1;
    check("rw_after_req", {31'd0, dif.req}, 1);
    check("rw_after_stall", {31'd0, o_stall_m}, 0);
    @(posedge i_clk); #1;
    check("rw_after_data", o_read_data_w, 32'h0BADF00D);
    check("rw_after_commit", {31'd0, o_regwrite_w}, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
